clk_sel_ctrl: RTL and testbench

CLK_SEL_CTRL -- requirements
Module: clk_sel_ctrl

---
 rtl/clk_sel_ctrl.sv | 263 ++++++++++++++++++++++++++
 tb/tb_clk_sel_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_sel_ctrl.sv
// -----------------------------------------------------------------------------
// clk_sel_ctrl
//
// Clock-select controller for a downstream glitch-free clock mux. It watches
// two candidate clocks, decides whether each is alive, and sequences
// switch requests and automatic failover. All logic runs on the reference
// clock c_clk_i.
//
// Liveness
//   Each candidate clock is sampled as plain asynchronous data. It passes
//   through a 2-flop synchronizer and then a third flop that acts as a
//   rising-edge detector, giving a one-cycle edge strobe. A shared window
//   counter runs 0..P_WIN-1. In each window, a per-clock counter counts edge
//   strobes and saturates at P_MIN_EDGES. In the wrap cycle the counter
//   result is loaded into s_alive_o[k] and the counter restarts. A strobe
//   that arrives in the wrap cycle counts toward the new window.
//
// Sequencing (IDLE -> SWITCH -> HOLD -> IDLE)
//   IDLE   : a request for the clock already selected gives a done pulse.
//            A request for a dead clock gives an error pulse. A request for
//            the other clock, if it is alive, loads the new select and
//            enters SWITCH.
//   SWITCH : lasts P_SETTLE cycles, then enters HOLD with a done pulse.
//   HOLD   : lasts P_DWELL cycles, then returns to IDLE.
//   Requests in SWITCH or HOLD are dropped with an error pulse.
//   Failover happens only in IDLE or HOLD, with s_auto_i set, the selected
//   clock dead and the other clock alive. It toggles the select and
//   restarts SWITCH. If a request arrives in the same cycle, the request
//   gets an error pulse.
//
// Parameters
//   P_WIN       activity window length in c_clk_i cycles (8..4096)
//   P_MIN_EDGES rising edges per window needed to count as alive (>= 1)
//   P_SETTLE    SWITCH length in cycles (>= 1)
//   P_DWELL     HOLD length in cycles (>= 1)
//
// Ports
//   c_clk_i      in   reference clock
//   s_rst_i      in   synchronous active-high reset
//   s_mon0_i     in   candidate clock 0 (asynchronous)
//   s_mon1_i     in   candidate clock 1 (asynchronous)
//   s_req_i      in   single-cycle switch request
//   s_req_sel_i  in   requested target clock, valid with s_req_i
//   s_auto_i     in   automatic failover enable
//   s_sel_o      out  registered clock-mux select
//   s_busy_o     out  high while in SWITCH or HOLD
//   s_done_o     out  one-cycle pulse: switch complete or no-op request
//   s_err_o      out  one-cycle pulse: rejected request
//   s_alive_o    out  per-clock liveness, bit k = clock k
// -----------------------------------------------------------------------------
module clk_sel_ctrl #(
    parameter int P_WIN       = 64,
    parameter int P_MIN_EDGES = 4,
    parameter int P_SETTLE    = 16,
    parameter int P_DWELL     = 256
) (
    input  logic       c_clk_i,
    input  logic       s_rst_i,
    input  logic       s_mon0_i,
    input  logic       s_mon1_i,
    input  logic       s_req_i,
    input  logic       s_req_sel_i,
    input  logic       s_auto_i,
    output logic       s_sel_o,
    output logic       s_busy_o,
    output logic       s_done_o,
    output logic       s_err_o,
    output logic [1:0] s_alive_o
);

    localparam int W_WIN     = $clog2(P_WIN);
    localparam int W_EDGE    = $clog2(P_MIN_EDGES + 1);
    localparam int P_TMR_MAX = (P_SETTLE > P_DWELL) ? P_SETTLE : P_DWELL;
    localparam int W_TMR     = $clog2(P_TMR_MAX + 1);

    // -------------------------------------------------------------------------
    // Shared activity window
    // -------------------------------------------------------------------------
    logic [W_WIN-1:0] win_cnt_reg;
    logic             win_wrap;

    assign win_wrap = (win_cnt_reg == W_WIN'(P_WIN - 1));

    always_ff @(posedge c_clk_i) begin
        if (s_rst_i) begin
            win_cnt_reg <= '0;
        end else if (win_wrap) begin
            win_cnt_reg <= '0;
        end else begin
            win_cnt_reg <= win_cnt_reg + W_WIN'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Per-clock synchronizer, edge detector and edge counter
    // -------------------------------------------------------------------------
    logic [1:0] mon_in;
    logic [1:0] alive_vec;

    assign mon_in = {s_mon1_i, s_mon0_i};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_mon
            // [0],[1] form the synchronizer; [2] is the delayed copy used
            // by the edge detector.
            logic [2:0]        sync_reg;
            logic              edge_stb;
            logic [W_EDGE-1:0] edge_cnt_reg;
            logic              alive_reg;

            assign edge_stb = sync_reg[1] & ~sync_reg[2];

            always_ff @(posedge c_clk_i) begin
                if (s_rst_i) begin
                    sync_reg <= 3'b000;
                end else begin
                    sync_reg <= {sync_reg[1:0], mon_in[gi]};
                end
            end

            always_ff @(posedge c_clk_i) begin
                if (s_rst_i) begin
                    edge_cnt_reg <= '0;
                    alive_reg    <= 1'b0;
                end else if (win_wrap) begin
                    // Saturation makes ">= P_MIN_EDGES" the same as
                    // "== P_MIN_EDGES". A strobe in this cycle starts the
                    // count for the next window.
                    alive_reg    <= (edge_cnt_reg == W_EDGE'(P_MIN_EDGES));
                    edge_cnt_reg <= W_EDGE'(edge_stb);
                end else if (edge_stb && (edge_cnt_reg != W_EDGE'(P_MIN_EDGES))) begin
                    edge_cnt_reg <= edge_cnt_reg + W_EDGE'(1);
                end
            end

            assign alive_vec[gi] = alive_reg;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Switch sequencer
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SWITCH = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [W_TMR-1:0] tmr_reg, tmr_next;
    logic             sel_reg, sel_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             err_reg, err_next;
    logic             err_pend_reg, err_pend_next;
    logic             err_raw;
    logic             failover;

    // Failover needs the selected clock dead and the other clock alive. If
    // both clocks are dead, the current select is kept.
    assign failover = s_auto_i && (state_reg != ST_SWITCH)
                      && !alive_vec[sel_reg] && alive_vec[~sel_reg];

    always_comb begin
        state_next    = state_reg;
        tmr_next      = tmr_reg;
        sel_next      = sel_reg;
        done_next     = 1'b0;
        err_raw       = 1'b0;
        err_next      = 1'b0;
        err_pend_next = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (failover) begin
                    sel_next   = ~sel_reg;
                    state_next = ST_SWITCH;
                    tmr_next   = '0;
                    err_raw    = s_req_i;
                end else if (s_req_i) begin
                    if (s_req_sel_i == sel_reg) begin
                        done_next = 1'b1;
                    end else if (!alive_vec[s_req_sel_i]) begin
                        err_raw = 1'b1;
                    end else begin
                        sel_next   = s_req_sel_i;
                        state_next = ST_SWITCH;
                        tmr_next   = '0;
                    end
                end
            end

            ST_SWITCH: begin
                err_raw = s_req_i;
                if (tmr_reg == W_TMR'(P_SETTLE - 1)) begin
                    state_next = ST_HOLD;
                    tmr_next   = '0;
                    done_next  = 1'b1;
                end else begin
                    tmr_next = tmr_reg + W_TMR'(1);
                end
            end

            ST_HOLD: begin
                err_raw = s_req_i;
                if (failover) begin
                    // Skip the rest of the dwell time and settle again on
                    // the clock that is still alive.
                    sel_next   = ~sel_reg;
                    state_next = ST_SWITCH;
                    tmr_next   = '0;
                end else if (tmr_reg == W_TMR'(P_DWELL - 1)) begin
                    state_next = ST_IDLE;
                    tmr_next   = '0;
                end else begin
                    tmr_next = tmr_reg + W_TMR'(1);
                end
            end

            default: begin
                state_next = ST_IDLE;
                tmr_next   = '0;
            end
        endcase

        // done and err must not pulse in the same cycle. The only case where
        // they would is a request dropped in the last SWITCH cycle. That
        // error is held one cycle and sent in the first HOLD cycle, which
        // can never carry a done pulse.
        err_pend_next = done_next & (err_raw | err_pend_reg);
        err_next      = ~done_next & (err_raw | err_pend_reg);

        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge c_clk_i) begin
        if (s_rst_i) begin
            state_reg    <= ST_IDLE;
            tmr_reg      <= '0;
            sel_reg      <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            err_pend_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tmr_reg      <= tmr_next;
            sel_reg      <= sel_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
            err_pend_reg <= err_pend_next;
        end
    end

    assign s_sel_o   = sel_reg;
    assign s_busy_o  = busy_reg;
    assign s_done_o  = done_reg;
    assign s_err_o   = err_reg;
    assign s_alive_o = alive_vec;

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_sel_ctrl
//
// Directed testbench for clk_sel_ctrl using the default parameters. The
// expected values are worked out by hand from cycle numbers. Cycle 0 is the
// first non-reset moment. Window wraps fall on cycles that are multiples
// of 64.
// -----------------------------------------------------------------------------
module tb_clk_sel_ctrl;

    logic       c_clk = 1'b0;
    logic       s_rst;
    logic       s_mon0 = 1'b0;
    logic       s_mon1 = 1'b1;
    logic       s_req;
    logic       s_req_sel;
    logic       s_auto;
    logic       s_sel;
    logic       s_busy;
    logic       s_done;
    logic       s_err;
    logic [1:0] s_alive;

    logic mon0_en = 1'b1;
    logic mon1_en = 1'b1;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    clk_sel_ctrl dut (
        .c_clk_i     (c_clk),
        .s_rst_i     (s_rst),
        .s_mon0_i    (s_mon0),
        .s_mon1_i    (s_mon1),
        .s_req_i     (s_req),
        .s_req_sel_i (s_req_sel),
        .s_auto_i    (s_auto),
        .s_sel_o     (s_sel),
        .s_busy_o    (s_busy),
        .s_done_o    (s_done),
        .s_err_o     (s_err),
        .s_alive_o   (s_alive)
    );

    always #5 c_clk = ~c_clk;

    // Monitored clocks run at 1/4 of the reference rate when enabled.
    always begin
        #20;
        if (mon0_en) s_mon0 = ~s_mon0;
    end

    always begin
        #20;
        if (mon1_en) s_mon1 = ~s_mon1;
    end

    task automatic tick();
        @(posedge c_clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end else begin
            $display("[TB] ok   %s @cyc %0d: %0h", tag, cyc, got);
        end
    endtask

    initial begin
        logic bad_done;
        logic bad_alive;
        logic bad_busy;

        s_rst     = 1'b1;
        s_req     = 1'b0;
        s_req_sel = 1'b0;
        s_auto    = 1'b0;
        repeat (3) tick();
        chk("rst_sel",   32'(s_sel),   32'd0);
        chk("rst_busy",  32'(s_busy),  32'd0);
        chk("rst_done",  32'(s_done),  32'd0);
        chk("rst_err",   32'(s_err),   32'd0);
        chk("rst_alive", 32'(s_alive), 32'd0);
        s_rst = 1'b0;
        cyc   = 0;

        // A request before the first window wrap is rejected.
        run_to(10);
        chk("early_alive", 32'(s_alive), 32'd0);
        s_req = 1'b1; s_req_sel = 1'b1;
        tick();
        s_req = 1'b0;
        chk("early_err", 32'(s_err), 32'd1);
        chk("early_sel", 32'(s_sel), 32'd0);
        tick();
        chk("early_err_clr", 32'(s_err), 32'd0);

        run_to(63);
        chk("alive_pre_wrap", 32'(s_alive), 32'd0);
        tick();
        chk("alive_wrap", 32'(s_alive), 32'd3);

        // No-op request for the clock already selected.
        s_req = 1'b1; s_req_sel = 1'b0;
        tick();
        s_req = 1'b0;
        chk("noop_done", 32'(s_done), 32'd1);
        chk("noop_busy", 32'(s_busy), 32'd0);
        chk("noop_err",  32'(s_err),  32'd0);

        // Switch to clock 1: select at 66, done at 82, idle at 338.
        s_req = 1'b1; s_req_sel = 1'b1;
        tick();
        s_req = 1'b0;
        chk("sw_sel",  32'(s_sel),  32'd1);
        chk("sw_busy", 32'(s_busy), 32'd1);
        chk("sw_done", 32'(s_done), 32'd0);

        run_to(70);
        s_req = 1'b1; s_req_sel = 1'b0;
        tick();
        s_req = 1'b0;
        chk("switch_req_err", 32'(s_err), 32'd1);
        chk("switch_req_sel", 32'(s_sel), 32'd1);

        run_to(81);
        chk("done_early", 32'(s_done), 32'd0);
        tick();
        chk("done_pulse", 32'(s_done), 32'd1);
        chk("done_noerr", 32'(s_err),  32'd0);
        tick();
        chk("done_clr",  32'(s_done), 32'd0);
        chk("hold_busy", 32'(s_busy), 32'd1);

        run_to(92);
        s_req = 1'b1; s_req_sel = 1'b1;
        tick();
        s_req = 1'b0;
        chk("hold_req_err",  32'(s_err),  32'd1);
        chk("hold_req_sel",  32'(s_sel),  32'd1);
        chk("hold_req_done", 32'(s_done), 32'd0);

        run_to(337);
        chk("dwell_busy", 32'(s_busy), 32'd1);
        tick();
        chk("dwell_end", 32'(s_busy), 32'd0);

        // Back to clock 0: select at 339, done at 355, idle at 611.
        s_req = 1'b1; s_req_sel = 1'b0;
        tick();
        s_req = 1'b0;
        chk("sw0_sel", 32'(s_sel), 32'd0);

        run_to(611);
        chk("sw0_idle", 32'(s_busy), 32'd0);
        s_auto = 1'b1;
        s_req  = 1'b1; s_req_sel = 1'b1;
        tick();
        s_req = 1'b0;
        chk("sw1_sel", 32'(s_sel), 32'd1);
        run_to(628);
        chk("sw1_done", 32'(s_done), 32'd1);

        // Clock 1 stops during HOLD. It is seen as dead at the wrap on
        // cycle 704. Failover at 705 wins over a request in that same cycle.
        run_to(640);
        mon1_en = 1'b0;
        run_to(703);
        chk("fo_alive_pre", 32'(s_alive), 32'd3);
        tick();
        chk("fo_alive", 32'(s_alive), 32'd1);
        chk("fo_sel_pre", 32'(s_sel), 32'd1);
        s_req = 1'b1; s_req_sel = 1'b0;
        tick();
        s_req = 1'b0;
        chk("fo_sel",  32'(s_sel),  32'd0);
        chk("fo_err",  32'(s_err),  32'd1);
        chk("fo_done", 32'(s_done), 32'd0);
        chk("fo_busy", 32'(s_busy), 32'd1);
        run_to(720);
        chk("fo_done_early", 32'(s_done), 32'd0);
        tick();
        chk("fo_done_pulse", 32'(s_done), 32'd1);

        // Both clocks dead: the select is kept and requests are rejected.
        run_to(768);
        chk("d_alive_01", 32'(s_alive), 32'd1);
        mon0_en = 1'b0;
        run_to(832);
        chk("d_alive_00", 32'(s_alive), 32'd0);
        chk("d_sel", 32'(s_sel), 32'd0);
        tick();
        chk("d_sel_held", 32'(s_sel), 32'd0);
        run_to(980);
        chk("d_idle", 32'(s_busy), 32'd0);
        s_req = 1'b1; s_req_sel = 1'b1;
        tick();
        s_req = 1'b0;
        chk("d_req_err", 32'(s_err), 32'd1);
        chk("d_req_sel", 32'(s_sel), 32'd0);

        // Restart both clocks, then reset in the middle of SWITCH.
        mon0_en = 1'b1;
        mon1_en = 1'b1;
        run_to(1024);
        chk("r_alive", 32'(s_alive), 32'd3);
        s_req = 1'b1; s_req_sel = 1'b1;
        tick();
        s_req = 1'b0;
        chk("r_sel", 32'(s_sel), 32'd1);
        run_to(1029);
        s_rst = 1'b1;
        tick();
        s_rst = 1'b0;
        chk("r_sel0",  32'(s_sel),   32'd0);
        chk("r_busy0", 32'(s_busy),  32'd0);
        chk("r_done0", 32'(s_done),  32'd0);
        chk("r_alive0", 32'(s_alive), 32'd0);
        cyc = 0;
        bad_done  = 1'b0;
        bad_alive = 1'b0;
        bad_busy  = 1'b0;
        for (int i = 0; i < 63; i++) begin
            tick();
            if (s_done)          bad_done  = 1'b1;
            if (s_alive != 2'b0) bad_alive = 1'b1;
            if (s_busy)          bad_busy  = 1'b1;
        end
        chk("r_no_done",   32'(bad_done),  32'd0);
        chk("r_alive_low", 32'(bad_alive), 32'd0);
        chk("r_no_busy",   32'(bad_busy),  32'd0);
        tick();
        chk("r_alive_back", 32'(s_alive), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
